multicycle_datapath: RTL and testbench
======================================

// Module: multicycle_datapath
// PURPOSE
//  16-bit multicycle RISC datapath; sequencing comes from an external controller.
//  Contains PC, IR, an 8x16 register file, an add/sub ALU, PSW flags, pipeline latches and a unified 256x16 memory.
//  Testbench port TBorNot takes over the memory so programs can be preloaded.
//  Feeds opcode, funct and flags back to the controller.
// PARAMETERS
//  DW 16  datapath width
//  AW 8   memory address width (256 words)
//  RN 8   register count (3-bit register addresses)
// PORTS
//  clk          in  1   single clock, all state updates on rising edge
//  Rst          in  1   reset, asynchronous, active-high
//  Buff_PC      in  1   PC <= OutNextPC
//  Buff_MEMIns  in  1   IR <= OutM
//  ALUorNot     in  1   RES source: 1 = IMM/MOV path, 0 = ALUOut
//  LIorMOV      in  1   when ALUorNot=1: 1 = B (MOV), 0 = IMM (load-immediate)
//  MEMresource  in  1   memory address: 1 = ALUOut[7:0], 0 = PC[7:0]
//  WE_MEM       in  1   memory write enable (datapath mode)
//  WBresource   in  1   writeback source: 1 = MDR, 0 = RES
//  RBresource   in  1   RB read address: 1 = IR[10:8], 0 = IR[4:2]
//  oprandB      in  1   ALU operand B: 1 = zero-extended IR[4:0], 0 = B register
//  LI           in  1   IMM: 1 = {IR[7:0], RB[7:0]} (LHI), 0 = {8'h00, IR[7:0]} (LLI)
//  PCplus1orWB  in  1   RF write data: 1 = writeback value, 0 = PC+1 (link)
//  WE_RF        in  1   RF write enable; write address is always IR[10:8]
//  Branch       in  1   taken branch (controller resolves the condition from PSW_NZC)
//  Jump         in  2   next-PC select, see BEHAVIOUR
//  ALUop        in  1   0 = add, 1 = subtract
//  Flag         in  1   1 = include PSW carry (ADC/SBC)
//  Buff_PSW     in  1   load PSW from the current ALU result
//  TBorNot      in  1   1 = memory driven by the Tb_* ports
//  Tb_MEMWE     in  1   testbench memory write enable
//  Tb_MEMAddr   in  8   testbench memory address
//  Tb_MEMData   in  16  testbench memory write data
//  OutR         out 16  combinational RF[IR[7:5]] (display port)
//  PSW_NZC      out 3   {N,Z,C}
//  opcode       out 5   IR[15:11]
//  ALUopcode    out 2   IR[1:0]
//  OutM         out 16  memory read data (asynchronous)
//  OutPC        out 16  PC
//  OutNextPC    out 16  next-PC mux output
// BEHAVIOUR
//  Reset: PC, IR, all RF entries, A, B, IMM, OPB, ALUOut, RES, MDR and PSW clear to 0.
//   So after reset OutPC=0, OutR=0, PSW_NZC=0, opcode=0, ALUopcode=0.
//   Memory is not reset.
//  Instruction formats:
//   [15:11] opcode, [10:8] Rd, [7:0] imm8
//   or [7:5] Ra, [4:2] Rb, [1:0] funct
//  Memory:
//   - Read is asynchronous; write is synchronous.
//   - TBorNot=1: addr/data/we come from Tb_MEMAddr, Tb_MEMData, Tb_MEMWE.
//   - TBorNot=0: addr from the MEMresource mux, data = B, we = WE_MEM.
//  Registers that latch every clock:
//   - A <= RF[IR[7:5]]
//   - B <= RF[RB mux]
//   - IMM <= LI mux
//   - OPB <= oprandB mux
//   - ALUOut <= ALU result
//   - RES <= ALUorNot/LIorMOV mux
//   - MDR <= OutM
//   The controller holds the decode selects (RBresource, oprandB, LI) stable until they are consumed.
//  ALU:
//   - add: {C,R} = A + OPB + (Flag & C)
//   - sub: {C,R} = A + ~OPB + (Flag ? C : 1)
//   - Result is 16 bits and wraps mod 2^16.
//   - On Buff_PSW: N = R[15], Z = (R==0), C = carry out.
//  Register file:
//   - Write at the clock edge when WE_RF=1; R0 is an ordinary register.
//   - Reads are combinational and return the old value during a same-cycle write.
//  Next PC:
//   - Jump=00: PC+1, or PC+1+sext(IR[7:0]) when Branch=1
//   - Jump=01: PC+1+sext(IR[10:0])
//   - Jump=10: A
//   - Jump=11: B
//  Reset mid-instruction aborts it; execution restarts with a fetch at address 0.
//  Typical 5-cycle sequence:
//   1. fetch: Buff_MEMIns=1
//   2. decode: select operands
//   3. execute: ALU, Buff_PSW
//   4. memory / RES select
//   5. writeback: WE_RF=1, PCplus1orWB=1, Buff_PC=1
// TESTING
//  - Preload (TBorNot=1): M[0]={0,R1,FF}, M[1]={0,R1,FF}, M[2]={0,R2,F1}, M[3]=ADD R3,R1,R2, M[4]=Ra=3, M[5]=ADC R4,R2,R3.
//    Then pulse Rst -> OutPC=0, OutR=0.
//  - Run LLI, LHI, LLI -> R1=00FF after instr 0, R1=FFFF after instr 1, R2=00F1, OutPC steps 0,1,2,3.
//  - ADD R3,R1,R2 (ALUop=0, Flag=0, Buff_PSW=1) -> R3=00F0, PSW_NZC=3'b001.
//    The fetch of M[4] then gives OutR=00F0.
//  - ADC R4,R2,R3 (Flag=1) -> R4=01E2.
//  - STR/LDR with oprandB=1, MEMresource=1:
//    STR R1 at A+4 -> OutM at that address = FFFF.
//    LDR (WBresource=1) -> Rd=FFFF.
//  - Branch=1 with IR[7:0]=FE at PC=5 -> OutNextPC=4.
//    Jump=10 -> OutNextPC=A.
//    Assert Rst mid-execute -> PC=0, PSW=0 immediately.

Source files
------------

// File: rtl/multicycle_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_datapath                                          |
// | Description : 16-bit multicycle RISC datapath driven by an external        |
// |               controller; unified 256x16 memory with a preload port.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module multicycle_datapath #(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int RN = 8
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          Buff_PC,
  input  logic          Buff_MEMIns,
  input  logic          ALUorNot,
  input  logic          LIorMOV,
  input  logic          MEMresource,
  input  logic          WE_MEM,
  input  logic          WBresource,
  input  logic          RBresource,
  input  logic          oprandB,
  input  logic          LI,
  input  logic          PCplus1orWB,
  input  logic          WE_RF,
  input  logic          Branch,
  input  logic [1:0]    Jump,
  input  logic          ALUop,
  input  logic          Flag,
  input  logic          Buff_PSW,
  input  logic          TBorNot,
  input  logic          Tb_MEMWE,
  input  logic [AW-1:0] Tb_MEMAddr,
  input  logic [DW-1:0] Tb_MEMData,
  output logic [DW-1:0] OutR,
  output logic [2:0]    PSW_NZC,
  output logic [4:0]    opcode,
  output logic [1:0]    ALUopcode,
  output logic [DW-1:0] OutM,
  output logic [DW-1:0] OutPC,
  output logic [DW-1:0] OutNextPC
);

  localparam int RAW = $clog2(RN);
  localparam int MD  = 1 << AW;
  localparam logic [DW-1:0] C_ONE = {{(DW-1){1'b0}}, 1'b1};

  logic [DW-1:0] pc_q, ir_q, a_q, b_q, imm_q, opb_q, aluout_q, res_q, mdr_q;
  logic [2:0]    psw_q;
  logic [DW-1:0] rf_q  [RN];
  logic [DW-1:0] mem_q [MD];

  logic [RAW-1:0] rd_addr, ra_addr, rb_addr;
  logic [DW-1:0]  ra_val, rb_val;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic           mem_we;
  logic [DW-1:0]  imm_d, opb_d, res_d, rf_d, pc_plus1, opb_eff;
  logic [2:0]     psw_d;
  logic           alu_cin;
  logic [DW:0]    alu_sum;

  assign rd_addr = ir_q[8 +: RAW];
  assign ra_addr = ir_q[5 +: RAW];
  assign rb_addr = RBresource ? rd_addr : ir_q[2 +: RAW];
  assign ra_val  = rf_q[ra_addr];
  assign rb_val  = rf_q[rb_addr];

  assign mem_addr  = TBorNot ? Tb_MEMAddr : (MEMresource ? aluout_q[AW-1:0] : pc_q[AW-1:0]);
  assign mem_wdata = TBorNot ? Tb_MEMData : b_q;
  assign mem_we    = TBorNot ? Tb_MEMWE   : WE_MEM;
  assign OutM      = mem_q[mem_addr];

  // Instruction format fixes the immediate halves at 8 bits each.
  assign imm_d = LI ? {ir_q[7:0], rb_val[7:0]} : {{(DW-8){1'b0}}, ir_q[7:0]};
  assign opb_d = oprandB ? {{(DW-5){1'b0}}, ir_q[4:0]} : b_q;
  assign res_d = ALUorNot ? (LIorMOV ? b_q : imm_q) : aluout_q;

  // Subtract is A + ~B + cin; with Flag the stored carry acts as not-borrow.
  always_comb begin
    opb_eff = ALUop ? ~opb_q : opb_q;
    alu_cin = ALUop ? (Flag ? psw_q[0] : 1'b1) : (Flag & psw_q[0]);
    alu_sum = {1'b0, a_q} + {1'b0, opb_eff} + {{DW{1'b0}}, alu_cin};
  end

  assign psw_d    = {alu_sum[DW-1], ~|alu_sum[DW-1:0], alu_sum[DW]};
  assign pc_plus1 = pc_q + C_ONE;
  assign rf_d     = PCplus1orWB ? (WBresource ? mdr_q : res_q) : pc_plus1;

  always_comb begin
    OutNextPC = pc_plus1;
    case (Jump)
      2'b00:   OutNextPC = Branch ? pc_plus1 + {{(DW-8){ir_q[7]}}, ir_q[7:0]} : pc_plus1;
      2'b01:   OutNextPC = pc_plus1 + {{(DW-11){ir_q[10]}}, ir_q[10:0]};
      2'b10:   OutNextPC = a_q;
      default: OutNextPC = b_q;
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      pc_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      opb_q    <= '0;
      aluout_q <= '0;
      res_q    <= '0;
      mdr_q    <= '0;
      psw_q    <= '0;
      for (int i = 0; i < RN; i++) rf_q[i] <= '0;
    end else begin
      if (Buff_PC)     pc_q <= OutNextPC;
      if (Buff_MEMIns) ir_q <= OutM;
      a_q      <= ra_val;
      b_q      <= rb_val;
      imm_q    <= imm_d;
      opb_q    <= opb_d;
      aluout_q <= alu_sum[DW-1:0];
      res_q    <= res_d;
      mdr_q    <= OutM;
      if (Buff_PSW) psw_q <= psw_d;
      if (WE_RF)    rf_q[rd_addr] <= rf_d;
    end
  end

  // Memory contents survive reset so preloaded programs are kept.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  assign OutR      = ra_val;
  assign PSW_NZC   = psw_q;
  assign opcode    = ir_q[15:11];
  assign ALUopcode = ir_q[1:0];
  assign OutPC     = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multicycle_datapath                                       |
// | Description : Directed program plus randomized instructions against a      |
// |               behavioural model of the multicycle datapath.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        Rst;
  logic        Buff_PC, Buff_MEMIns, ALUorNot, LIorMOV, MEMresource, WE_MEM;
  logic        WBresource, RBresource, oprandB, LI, PCplus1orWB, WE_RF, Branch;
  logic [1:0]  Jump;
  logic        ALUop, Flag, Buff_PSW, TBorNot, Tb_MEMWE;
  logic [7:0]  Tb_MEMAddr;
  logic [15:0] Tb_MEMData;
  logic [15:0] OutR, OutM, OutPC, OutNextPC;
  logic [2:0]  PSW_NZC;
  logic [4:0]  opcode;
  logic [1:0]  ALUopcode;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multicycle_datapath dut (
    .clk(clk), .Rst(Rst), .Buff_PC(Buff_PC), .Buff_MEMIns(Buff_MEMIns),
    .ALUorNot(ALUorNot), .LIorMOV(LIorMOV), .MEMresource(MEMresource),
    .WE_MEM(WE_MEM), .WBresource(WBresource), .RBresource(RBresource),
    .oprandB(oprandB), .LI(LI), .PCplus1orWB(PCplus1orWB), .WE_RF(WE_RF),
    .Branch(Branch), .Jump(Jump), .ALUop(ALUop), .Flag(Flag), .Buff_PSW(Buff_PSW),
    .TBorNot(TBorNot), .Tb_MEMWE(Tb_MEMWE), .Tb_MEMAddr(Tb_MEMAddr),
    .Tb_MEMData(Tb_MEMData), .OutR(OutR), .PSW_NZC(PSW_NZC), .opcode(opcode),
    .ALUopcode(ALUopcode), .OutM(OutM), .OutPC(OutPC), .OutNextPC(OutNextPC)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl;
    {Buff_PC, Buff_MEMIns, ALUorNot, LIorMOV, MEMresource, WE_MEM} = '0;
    {WBresource, RBresource, oprandB, LI, PCplus1orWB, WE_RF, Branch} = '0;
    {Jump, ALUop, Flag, Buff_PSW} = '0;
  endtask

  task automatic sel(input bit aon, input bit lom, input bit rbr, input bit opb, input bit li,
                     input bit aop, input bit flg, input bit mres, input bit wbr, input bit p1w);
    ALUorNot = aon; LIorMOV = lom; RBresource = rbr; oprandB = opb; LI = li;
    ALUop = aop; Flag = flg; MEMresource = mres; WBresource = wbr; PCplus1orWB = p1w;
  endtask

  task automatic tb_write(input logic [7:0] addr, input logic [15:0] data);
    TBorNot = 1'b1; Tb_MEMWE = 1'b1; Tb_MEMAddr = addr; Tb_MEMData = data;
    step;
    Tb_MEMWE = 1'b0; TBorNot = 1'b0;
  endtask

  task automatic fetch;
    clear_ctl();
    Buff_MEMIns = 1'b1;
    step;
    Buff_MEMIns = 1'b0;
  endtask

  // Operand, ALU, memory and result latches each need one edge to settle.
  task automatic exec_pre(input bit psw_en, input bit we_mem_en);
    step;
    step;
    Buff_PSW = psw_en;
    step;
    Buff_PSW = 1'b0;
    WE_MEM = we_mem_en;
    step;
    WE_MEM = 1'b0;
  endtask

  task automatic commit(input bit we_rf_en);
    WE_RF = we_rf_en; Buff_PC = 1'b1;
    step;
    WE_RF = 1'b0; Buff_PC = 1'b0;
  endtask

  // Loads a word with Ra=r into IR through the preload port to observe RF[r].
  task automatic probe(input logic [2:0] r, input logic [15:0] exp, input string tag);
    clear_ctl();
    tb_write(8'hFF, {5'h1F, 3'd0, r, 5'd0});
    TBorNot = 1'b1; Tb_MEMAddr = 8'hFF; Buff_MEMIns = 1'b1;
    step;
    Buff_MEMIns = 1'b0; TBorNot = 1'b0;
    check(tag, OutR, exp);
  endtask

  task automatic run_random(input int n);
    logic [15:0] m_rf [8];
    logic [15:0] m_pc, word, a, b, res;
    logic [2:0]  rd, ra, rb;
    logic [7:0]  imm8;
    logic        m_n, m_z, m_c, op, fl, pe, taken, we;
    int          kind, off, r;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_pc = '0; m_n = 0; m_z = 0; m_c = 0;
    for (int k = 0; k < n; k++) begin
      kind = $urandom_range(0, 6);
      rd = 3'($urandom); ra = 3'($urandom); rb = 3'($urandom); imm8 = 8'($urandom);
      op = 1'($urandom); fl = 1'($urandom); pe = 1'($urandom); taken = 1'($urandom);
      off = $urandom_range(0, 40) - 20;
      if (int'(m_pc) + 1 + off < 0 || int'(m_pc) + 1 + off > 200) off = -off;
      case (kind)
        0: word = {5'h10, rd, imm8};
        1: word = {5'h11, rd, imm8};
        2: word = {5'h12, rd, ra, rb, 2'b00};
        3: word = {5'h13, rd, ra, rb, op, fl};
        4: word = {5'h14, rd, ra, imm8[4:0]};
        5: word = {5'h15, 3'd0, 8'(off)};
        default: word = {5'h16, 11'(off)};
      endcase
      if (kind == 6) rd = word[10:8];
      tb_write(m_pc[7:0], word);
      fetch();
      check("rnd_opcode", {11'd0, opcode}, {11'd0, word[15:11]});
      check("rnd_funct", {14'd0, ALUopcode}, {14'd0, word[1:0]});
      we = 1'b1;
      case (kind)
        0: begin sel(1,0,1,0,0, 0,0,0,0,1); m_rf[rd] = {8'h00, imm8}; end
        1: begin sel(1,0,1,0,1, 0,0,0,0,1); m_rf[rd] = {imm8, m_rf[rd][7:0]}; end
        2: begin sel(1,1,0,0,0, 0,0,0,0,1); m_rf[rd] = m_rf[rb]; end
        3, 4: begin
          sel(0,0,0,(kind == 4),0, op,fl,0,0,1);
          a = m_rf[ra];
          b = (kind == 4) ? {11'd0, imm8[4:0]} : m_rf[rb];
          if (!op) r = int'(a) + int'(b) + ((fl && m_c) ? 1 : 0);
          else     r = int'(a) - int'(b) - ((fl && !m_c) ? 1 : 0);
          res = r[15:0];
          if (pe) begin
            m_c = op ? (r >= 0) : (r > 65535);
            m_n = res[15];
            m_z = (res == 16'd0);
          end
          m_rf[rd] = res;
        end
        5: begin Branch = taken; we = 1'b0; end
        default: begin Jump = 2'b01; PCplus1orWB = 1'b0; end
      endcase
      exec_pre((kind == 3 || kind == 4) ? pe : 1'b0, 1'b0);
      if (kind == 6) m_rf[rd] = m_pc + 16'd1;
      if (kind == 5 && taken || kind == 6) m_pc = 16'(int'(m_pc) + 1 + off);
      else m_pc = m_pc + 16'd1;
      check("rnd_nextpc", OutNextPC, m_pc);
      commit(we);
      check("rnd_pc", OutPC, m_pc);
      check("rnd_psw", {13'd0, PSW_NZC}, {13'd0, m_n, m_z, m_c});
      if (!we) rd = rb;
      probe(rd, m_rf[rd], "rnd_rf");
    end
  endtask

  initial begin
    clear_ctl();
    TBorNot = 1'b0; Tb_MEMWE = 1'b0; Tb_MEMAddr = '0; Tb_MEMData = '0;
    Rst = 1'b1;
    step;
    Rst = 1'b0;
    tb_write(8'd0, 16'h01FF);
    tb_write(8'd1, 16'h01FF);
    tb_write(8'd2, 16'h02F1);
    tb_write(8'd3, 16'h0B28);
    tb_write(8'd4, 16'h0060);
    tb_write(8'd5, 16'h0C4D);
    tb_write(8'd6, 16'h1144);
    tb_write(8'd7, 16'h1D44);
    tb_write(8'd8, 16'h0605);
    tb_write(8'd9, 16'h20C0);
    Rst = 1'b1;
    step;
    Rst = 1'b0;
    check("rst_pc", OutPC, 16'h0000);
    check("rst_outr", OutR, 16'h0000);
    check("rst_psw", {13'd0, PSW_NZC}, 16'h0000);
    check("rst_opcode", {11'd0, opcode}, 16'h0000);
    check("rst_funct", {14'd0, ALUopcode}, 16'h0000);

    fetch(); sel(1,0,1,0,0, 0,0,0,0,1); exec_pre(0,0); commit(1);
    check("lli_pc", OutPC, 16'd1);
    probe(3'd1, 16'h00FF, "lli_r1");
    fetch(); sel(1,0,1,0,1, 0,0,0,0,1); exec_pre(0,0); commit(1);
    check("lhi_pc", OutPC, 16'd2);
    probe(3'd1, 16'hFFFF, "lhi_r1");
    fetch(); sel(1,0,1,0,0, 0,0,0,0,1); exec_pre(0,0); commit(1);
    check("lli2_pc", OutPC, 16'd3);
    probe(3'd2, 16'h00F1, "lli_r2");

    fetch();
    check("add_opcode", {11'd0, opcode}, 16'd1);
    sel(0,0,0,0,0, 0,0,0,0,1); exec_pre(1,0); commit(1);
    check("add_psw", {13'd0, PSW_NZC}, 16'h0001);
    probe(3'd3, 16'h00F0, "add_r3");
    fetch();
    check("fetch4_outr", OutR, 16'h00F0);
    exec_pre(0,0); commit(0);

    fetch();
    check("adc_funct", {14'd0, ALUopcode}, 16'd1);
    sel(0,0,0,0,0, 0,1,0,0,1); exec_pre(0,0); commit(1);
    check("adc_psw_held", {13'd0, PSW_NZC}, 16'h0001);
    probe(3'd4, 16'h01E2, "adc_r4");

    fetch(); sel(0,0,1,1,0, 0,0,1,0,1); exec_pre(0,1); commit(0);
    check("str_pc", OutPC, 16'd7);
    TBorNot = 1'b1; Tb_MEMAddr = 8'hF5; #1;
    check("str_mem", OutM, 16'hFFFF);
    TBorNot = 1'b0;
    fetch(); sel(0,0,0,1,0, 0,0,1,1,1); exec_pre(0,0); commit(1);
    probe(3'd5, 16'hFFFF, "ldr_r5");

    fetch(); sel(1,0,1,0,0, 0,0,0,0,1); exec_pre(0,0); commit(1);
    fetch(); Jump = 2'b10; exec_pre(0,0);
    check("jr_nextpc", OutNextPC, 16'd5);
    commit(0);
    check("jr_pc", OutPC, 16'd5);
    tb_write(8'd5, 16'h28FE);
    fetch(); Branch = 1'b1; exec_pre(0,0);
    check("br_nextpc", OutNextPC, 16'd4);
    commit(0);
    check("br_pc", OutPC, 16'd4);

    fetch(); step; step;
    Rst = 1'b1; #1;
    check("midrst_pc", OutPC, 16'h0000);
    check("midrst_psw", {13'd0, PSW_NZC}, 16'h0000);
    check("midrst_outr", OutR, 16'h0000);
    step;
    Rst = 1'b0;

    run_random(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no summary expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
